buf_array_bist: RTL and testbench

BUF_ARRAY_BIST -- requirements
Module: buf_array_bist

---
 rtl/bist_pkg.sv | 28 ++
 rtl/buf_array_fi.sv | 23 ++
 rtl/buf_array_bist.sv | 85 ++++++++
 tb/tb_buf_array_bist.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM states, per-width LFSR tap masks and the
// step function used by both the pattern LFSR and the signature MISR.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Feedback taps per width, bit W-1 always included. A single extra tap is
  // used where a primitive trinomial exists; 8/12/13/14/16 need four taps.
  localparam logic [15:0] TAP_MASK [4:16] = '{
    16'h0009, 16'h0012, 16'h0021, 16'h0041, 16'h008E, 16'h0108, 16'h0204,
    16'h0402, 16'h0CA0, 16'h1B00, 16'h3500, 16'h4001, 16'h8805
  };

  function automatic logic [15:0] tap_mask(input int unsigned w);
    return (w >= 4 && w <= 16) ? TAP_MASK[w] : 16'h0009;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s, input int unsigned w);
    logic fb;
    fb = ^(s & tap_mask(w));
    return {s[14:0], fb} & ~(16'hFFFF << w);
  endfunction

endpackage

// File: rtl/buf_array_fi.sv
// Buffer array under test with single-channel stuck-at injection.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output always reflects the current inputs.
module buf_array_fi #(
  parameter int WIDTH = 4,
  parameter int SELW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] pattern,
  input  logic             fault_en,
  input  logic [SELW-1:0]  fault_sel,
  input  logic             fault_val,
  output logic [WIDTH-1:0] response
);

  // An out-of-range select matches no channel, so nothing is injected.
  always_comb begin
    response = pattern;
    for (int i = 0; i < WIDTH; i++) begin
      if (fault_en && fault_sel == SELW'(i)) response[i] = fault_val;
    end
  end

endmodule

// File: rtl/buf_array_bist.sv
// LFSR/MISR BIST wrapper around the buffer array: FSM, pattern counter, LFSR, MISR.
// Latency: NPAT RUN cycles after start is sampled, then DONE.
// Backpressure: none; start is honoured only in IDLE or DONE, ignored in RUN.
module buf_array_bist
  import bist_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter int               NPAT  = 15,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       fault_en,
  input  logic [$clog2(WIDTH)-1:0]   fault_sel,
  input  logic                       fault_val,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           pattern,
  output logic [WIDTH-1:0]           response,
  output logic [WIDTH-1:0]           signature
);

  localparam int SELW = $clog2(WIDTH);
  localparam int CNTW = $clog2(NPAT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NPAT - 1);

  state_t          state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] misr;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] misr_nxt;
  logic [CNTW-1:0]  cnt;
  logic             fault_en_q;
  logic [SELW-1:0]  fault_sel_q;
  logic             fault_val_q;
  logic             enter_run;

  buf_array_fi #(
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) u_array (
    .pattern   (lfsr),
    .fault_en  (fault_en_q),
    .fault_sel (fault_sel_q),
    .fault_val (fault_val_q),
    .response  (response)
  );

  assign lfsr_nxt  = WIDTH'(lfsr_step(16'(lfsr), WIDTH));
  assign misr_nxt  = WIDTH'(lfsr_step(16'(misr), WIDTH)) ^ response;
  assign enter_run = start && (state != ST_RUN);

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign pattern   = lfsr;
  assign signature = misr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      lfsr        <= SEED;
      misr        <= '0;
      cnt         <= '0;
      fault_en_q  <= 1'b0;
      fault_sel_q <= '0;
      fault_val_q <= 1'b0;
    end else if (enter_run) begin
      // Every run starts from a clean seed so signatures are repeatable.
      state       <= ST_RUN;
      lfsr        <= SEED;
      misr        <= '0;
      cnt         <= '0;
      fault_en_q  <= fault_en;
      fault_sel_q <= fault_sel;
      fault_val_q <= fault_val;
    end else if (state == ST_RUN) begin
      lfsr <= lfsr_nxt;
      misr <= misr_nxt;
      cnt  <= cnt + CNTW'(1);
      if (cnt == CNT_LAST) state <= ST_DONE;
    end
  end

endmodule

// File: tb/tb_buf_array_bist.sv
// Self-checking bench: pattern table + MISR model for WIDTH=4, uniqueness sweep for WIDTH=8.
module tb_buf_array_bist;

  localparam int NPAT4 = 15;
  localparam logic [3:0] PAT [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                      4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       fault_en = 1'b0;
  logic [1:0] fault_sel = 2'd0;
  logic       fault_val = 1'b0;
  logic       busy, done;
  logic [3:0] pattern, response, signature;

  logic       start8 = 1'b0;
  logic       fault_en8 = 1'b0;
  logic [2:0] fault_sel8 = 3'd0;
  logic       fault_val8 = 1'b0;
  logic       busy8, done8;
  logic [7:0] pattern8, response8, signature8;

  int n_chk = 0;
  int n_pass = 0;

  logic       exp_vld = 1'b0;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  logic [3:0] exp_pat = 4'h0;
  logic [3:0] exp_resp = 4'h0;
  logic [3:0] exp_sig = 4'h0;

  always #5 clk = ~clk;

  buf_array_bist u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fault_en  (fault_en),
    .fault_sel (fault_sel),
    .fault_val (fault_val),
    .busy      (busy),
    .done      (done),
    .pattern   (pattern),
    .response  (response),
    .signature (signature)
  );

  buf_array_bist #(.WIDTH(8), .NPAT(255), .SEED(8'h01)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .fault_en  (fault_en8),
    .fault_sel (fault_sel8),
    .fault_val (fault_val8),
    .busy      (busy8),
    .done      (done8),
    .pattern   (pattern8),
    .response  (response8),
    .signature (signature8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] flt(input logic [3:0] p, input logic fe,
                                     input logic [1:0] fs, input logic fv);
    logic [3:0] r;
    r = p;
    if (fe) r[fs] = fv;
    return r;
  endfunction

  function automatic logic [3:0] mstep(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[0]};
  endfunction

  function automatic logic [3:0] model_sig(input logic fe, input logic [1:0] fs, input logic fv);
    logic [3:0] s;
    s = 4'h0;
    for (int k = 0; k < NPAT4; k++) s = mstep(s) ^ flt(PAT[k], fe, fs, fv);
    return s;
  endfunction

  task automatic set_exp(input logic b, input logic d, input logic [3:0] p,
                         input logic [3:0] r, input logic [3:0] s);
    exp_busy = b;
    exp_done = d;
    exp_pat  = p;
    exp_resp = r;
    exp_sig  = s;
    exp_vld  = 1'b1;
  endtask

  // Compare process: away from the active edge, every cycle expectations are live.
  always @(negedge clk) begin
    if (exp_vld) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("pattern", 32'(pattern), 32'(exp_pat));
      check("response", 32'(response), 32'(exp_resp));
      check("signature", 32'(signature), 32'(exp_sig));
    end
  end

  // Called just after an active edge; leaves the DUT in DONE (or IDLE on abort).
  task automatic do_run(input logic fe, input logic [1:0] fs, input logic fv,
                        input logic hold, input logic rnd, input int abort_at,
                        output logic [3:0] sig_out);
    logic [3:0] s, r;
    fault_en  = fe;
    fault_sel = fs;
    fault_val = fv;
    start     = 1'b1;
    s = 4'h0;
    for (int k = 0; k < NPAT4; k++) begin
      @(posedge clk); #1;
      start = hold ? 1'b1 : (rnd ? 1'($urandom) : 1'b0);
      if (rnd) begin
        fault_en  = 1'($urandom);
        fault_sel = 2'($urandom);
        fault_val = 1'($urandom);
      end
      r = flt(PAT[k], fe, fs, fv);
      set_exp(1'b1, 1'b0, PAT[k], r, s);
      s = mstep(s) ^ r;
      if (k == abort_at) begin
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        set_exp(1'b0, 1'b0, 4'h1, 4'h1, 4'h0);
        sig_out = 4'h0;
        return;
      end
    end
    @(posedge clk); #1;
    start = hold;
    set_exp(1'b0, 1'b1, PAT[0], flt(PAT[0], fe, fs, fv), s);
    sig_out = s;
  endtask

  task automatic idle(input int n, input logic rnd);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd) begin
        fault_en  = 1'($urandom);
        fault_sel = 2'($urandom);
        fault_val = 1'($urandom);
      end
    end
  endtask

  initial begin
    logic [3:0] sig, clean;
    int n, cov_dut, cov_mod, distinct, dups, zeros, resp_err;
    bit seen [256];

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    set_exp(1'b0, 1'b0, 4'h1, 4'h1, 4'h0);
    idle(3, 1'b0);

    // Hand-derived signatures pin the model.
    check("pin_model_clean", 32'(model_sig(1'b0, 2'd0, 1'b0)), 32'h8);
    check("pin_model_sa0_ch0", 32'(model_sig(1'b1, 2'd0, 1'b0)), 32'h9);

    // Start-to-done latency, counting the edge that samples start.
    exp_vld = 1'b0;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      if (n == 1) start = 1'b0;
    end while (!done && n < 100);
    check("done_latency_w4", 32'(n), 32'd16);
    set_exp(1'b0, 1'b1, 4'h1, 4'h1, 4'h8);
    idle(2, 1'b0);

    do_run(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, -1, clean);
    idle(2, 1'b0);
    do_run(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, -1, sig);
    idle(2, 1'b0);

    cov_dut = 0;
    cov_mod = 0;
    for (int ch = 0; ch < 4; ch++) begin
      for (int v = 0; v < 2; v++) begin
        do_run(1'b1, 2'(ch), 1'(v), 1'b0, 1'b0, -1, sig);
        #1;
        if (signature !== clean) cov_dut++;
        if (model_sig(1'b1, 2'(ch), 1'(v)) != model_sig(1'b0, 2'd0, 1'b0)) cov_mod++;
      end
    end
    check("fault_coverage", 32'(cov_dut), 32'(cov_mod));
    $display("fault coverage: %0d of 8 stuck-at faults detected", cov_dut);

    do_run(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6, sig);
    idle(3, 1'b0);
    do_run(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, -1, sig);
    idle(1, 1'b0);

    do_run(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, -1, sig);
    do_run(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, -1, sig);

    repeat (20) begin
      do_run(1'($urandom), 2'($urandom), 1'($urandom), 1'b0, 1'b1, -1, sig);
      idle($urandom_range(0, 4), 1'b1);
    end

    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct = 0;
    dups = 0;
    zeros = 0;
    resp_err = 0;
    start8 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      if (n == 1) start8 = 1'b0;
      if (busy8) begin
        if (response8 !== pattern8) resp_err++;
        if (pattern8 == 8'h00) zeros++;
        else if (seen[pattern8]) dups++;
        else begin
          seen[pattern8] = 1'b1;
          distinct++;
        end
      end
    end while (!done8 && n < 1000);
    check("done_latency_w8", 32'(n), 32'd256);
    check("w8_distinct", 32'(distinct), 32'd255);
    check("w8_dups", 32'(dups), 32'd0);
    check("w8_zero_pattern", 32'(zeros), 32'd0);
    check("w8_response", 32'(resp_err), 32'd0);
    check("w8_busy_in_done", 32'(busy8), 32'd0);

    exp_vld = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
